aes_round_ctrl: RTL and testbench

- Round sequencer for the AES-128/192/256 encryption datapath. It drives the round number and stage enables consumed by the SubBytes stage, and the ShiftRows, MixColumns and AddRoundKey stages.
- It accepts one plaintext block per valid/ready handshake and waits for the key-expansion block to present each round key. It strobes the state-register write once per round and presents the result on a valid/ready output handshake.
- It sits between the top-level I/O wrapper and the round datapath; it controls sequencing only and carries no data.

---
 rtl/aes_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : Round sequencer for the AES-128/192/256 encryption datapath.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       key_req,
    input  logic       key_rdy,
    output logic [3:0] round,
    output logic       enbsb,
    output logic       enbsr,
    output logic       enbmc,
    output logic       enbark,
    output logic       state_we,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] c_last_round = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       in_ready_q, in_ready_d;
    logic       key_req_q, key_req_d;
    logic       enbsb_q, enbsb_d;
    logic       enbsr_q, enbsr_d;
    logic       enbmc_q, enbmc_d;
    logic       enbark_q, enbark_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (key_rdy) begin
                    state_d = S_RUN;
                    round_d = 4'd1;
                end
            end
            S_RUN: begin
                if (key_rdy) begin
                    if (round_q == c_last_round) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned
    // with state_q, keeping every datapath control glitch-free.
    always_comb begin
        in_ready_d  = 1'b0;
        key_req_d   = 1'b0;
        enbsb_d     = 1'b0;
        enbsr_d     = 1'b0;
        enbmc_d     = 1'b0;
        enbark_d    = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        unique case (state_d)
            S_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            S_INIT: begin
                key_req_d = 1'b1;
                enbark_d  = 1'b1;
            end
            S_RUN: begin
                key_req_d = 1'b1;
                enbsb_d   = 1'b1;
                enbsr_d   = 1'b1;
                enbmc_d   = (round_d != c_last_round);
                enbark_d  = 1'b1;
            end
            S_DONE: begin
                out_valid_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b1;
            key_req_q   <= 1'b0;
            enbsb_q     <= 1'b0;
            enbsr_q     <= 1'b0;
            enbmc_q     <= 1'b0;
            enbark_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            key_req_q   <= key_req_d;
            enbsb_q     <= enbsb_d;
            enbsr_q     <= enbsr_d;
            enbmc_q     <= enbmc_d;
            enbark_q    <= enbark_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The write strobe follows key_rdy within the same cycle so a round
    // commits on the very edge its key arrives.
    assign state_we  = key_rdy && ((state_q == S_INIT) || (state_q == S_RUN)) && !rst;

    assign in_ready  = in_ready_q;
    assign key_req   = key_req_q;
    assign round     = round_q;
    assign enbsb     = enbsb_q;
    assign enbsr     = enbsr_q;
    assign enbmc     = enbmc_q;
    assign enbark    = enbark_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Brief    : Scoreboard bench for aes_round_ctrl (NR=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       key_req;
    logic       key_rdy;
    logic [3:0] round;
    logic       enbsb;
    logic       enbsr;
    logic       enbmc;
    logic       enbark;
    logic       state_we;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_req   (key_req),
        .key_rdy   (key_rdy),
        .round     (round),
        .enbsb     (enbsb),
        .enbsr     (enbsr),
        .enbmc     (enbmc),
        .enbark    (enbark),
        .state_we  (state_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [3:0] rnd;
        logic       sb;
        logic       sr;
        logic       mc;
        logic       ark;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One entry per expected state_we pulse (rounds 0..NR), then the output handshake.
    task automatic push_block();
        exp_t e;
        for (int r = 0; r <= NR; r++) begin
            e.is_done = 1'b0;
            e.rnd     = 4'(r);
            e.sb      = (r != 0);
            e.sr      = (r != 0);
            e.mc      = (r != 0) && (r != NR);
            e.ark     = 1'b1;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.rnd     = 4'(NR);
        e.sb      = 1'b0;
        e.sr      = 1'b0;
        e.mc      = 1'b0;
        e.ark     = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops and compares on each DUT event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (state_we === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    check("sb_unexpected_state_we", {28'd0, round}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_we_round", round, e.rnd);
                    check("sb_we_enables", {key_req, enbsb, enbsr, enbmc, enbark},
                          {1'b1, e.sb, e.sr, e.mc, e.ark});
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    check("sb_unexpected_output", {28'd0, round}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_round", round, e.rnd);
                    check("sb_out_ctrl", {in_ready, key_req, enbsb, enbsr, enbmc, enbark},
                          {1'b0, 1'b0, e.sb, e.sr, e.mc, e.ark});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Issues one block from IDLE at posedge+1; optional key stall and DONE hold.
    task automatic run_block(input int stall_round, input int stall_len,
                             input int hold_done, output int lat);
        int stalls;
        bit in_stall;
        push_block();
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat    = 0;
        stalls = 0;
        while (lat < 200) begin
            in_stall = (stalls < stall_len) && (int'(round) == stall_round) && key_req;
            key_rdy  = !in_stall;
            @(negedge clk);
            if (in_stall) begin
                stalls++;
                check("stall_round_held", round, stall_round);
                check("stall_no_we", state_we, 0);
                check("stall_enables", {key_req, enbsb, enbsr, enbmc, enbark}, 5'b11111);
            end
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        key_rdy = 1'b1;
        check("out_valid_reached", out_valid, 1);
        @(posedge clk); #1;
        for (int i = 0; i < hold_done; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("done_hold_out_valid", out_valid, 1);
            check("done_hold_round", round, NR);
            check("done_hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_done_in_ready", in_ready, 1);
        check("post_done_round", round, 0);
        check("post_done_busy_valid", {busy, out_valid}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int n;
        int acc;
        int acc_cyc[2];

        rst       = 1'b1;
        in_valid  = 1'b0;
        key_rdy   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_round", round, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctrl", {key_req, enbsb, enbsr, enbmc, enbark}, 5'b00000);
        check("rst_state_we", state_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_we_with_key_rdy", state_we, 0);
        @(posedge clk); #1;

        run_block(-1, 0, 0, lat);
        check("latency_plain", lat, NR + 1);

        run_block(4, 3, 0, lat);
        check("latency_stalled", lat, NR + 4);

        run_block(-1, 0, 5, lat);
        check("latency_done_hold", lat, NR + 1);

        // Reset in the middle of round 6.
        push_block();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (round != 4'd6 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_round6", round, 6);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_we", state_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("after_rst_round", round, 0);
        check("after_rst_in_ready", in_ready, 1);
        check("after_rst_busy_valid", {busy, out_valid, key_req}, 3'b000);
        @(posedge clk); #1;

        run_block(-1, 0, 0, lat);
        check("latency_after_rst", lat, NR + 1);

        // Back-to-back blocks with in_valid and out_ready held high.
        push_block();
        push_block();
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        acc        = 0;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        for (int c = 0; c <= 2 * NR + 5; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (acc < 2) acc_cyc[acc] = c;
                acc++;
            end
            @(posedge clk); #1;
            if (acc >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("b2b_accept_count", acc, 2);
        check("b2b_first_accept", acc_cyc[0], 0);
        check("b2b_second_accept", acc_cyc[1], NR + 3);
        @(negedge clk);
        check("b2b_idle_at_end", {busy, in_ready}, 2'b01);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
